// File: rtl/dvi_timing_gen_if.sv
// dvi_timing_gen_if: raster timing bus between the timing generator and the TMDS encoder/pixel source.
//   ce          pixel-advance enable (driven by slave)
//   x, y        current pixel column / line
//   dena        active video flag
//   hsync/vsync sync pulses in configured polarity
//   ctrl        {vsync,hsync} for encoder channel 0
//   line_start  first pixel of each line
//   frame_start first pixel of each frame
interface dvi_timing_gen_if #(parameter int CW = 11);
  logic          ce;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          dena;
  logic          hsync;
  logic          vsync;
  logic [1:0]    ctrl;
  logic          line_start;
  logic          frame_start;
  modport master (input ce, output x, y, dena, hsync, vsync, ctrl, line_start, frame_start);
  modport slave (output ce, input x, y, dena, hsync, vsync, ctrl, line_start, frame_start);
endinterface

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: video raster timing generator feeding the TMDS encoders.
//   clk   pixel-domain clock
//   rstn  asynchronous active-low reset
//   bus   timing bus (master side): ce in; x, y, dena, hsync, vsync, ctrl, line_start, frame_start out
module dvi_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input logic              clk,
  input logic              rstn,
  dvi_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // Range bounds carry one extra bit so an end bound equal to 2**CW still compares correctly.
  localparam logic [CW:0] H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] r_h, r_v, w_h_nxt, w_v_nxt;
  logic [CW:0]   w_hx, w_vx;
  logic          r_dena, r_hs, r_vs, r_ls, r_fs;
  logic          w_dena, w_hs, w_vs;
  // Outputs are decoded from the next count so they land in the same cycle as x/y.
  always_comb begin
    w_h_nxt = (r_h == H_LAST) ? '0 : r_h + 1'b1;
    w_v_nxt = (r_h != H_LAST) ? r_v : (r_v == V_LAST) ? '0 : r_v + 1'b1;
    w_hx    = {1'b0, w_h_nxt};
    w_vx    = {1'b0, w_v_nxt};
    w_dena  = (w_hx < H_ACT) && (w_vx < V_ACT);
    w_hs    = (w_hx >= HS_BEG && w_hx < HS_END) ? HS_POL : ~HS_POL;
    w_vs    = (w_vx >= VS_BEG && w_vx < VS_END) ? VS_POL : ~VS_POL;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_h    <= H_LAST;
      r_v    <= V_LAST;
      r_dena <= 1'b0;
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end else if (bus.ce) begin
      r_h    <= w_h_nxt;
      r_v    <= w_v_nxt;
      r_dena <= w_dena;
      r_hs   <= w_hs;
      r_vs   <= w_vs;
      r_ls   <= (w_h_nxt == '0);
      r_fs   <= (w_h_nxt == '0) && (w_v_nxt == '0);
    end
  assign bus.x           = r_h;
  assign bus.y           = r_v;
  assign bus.dena        = r_dena;
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.ctrl        = {r_vs, r_hs};
  assign bus.line_start  = r_ls;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb_dvi_timing_gen: checks a default-timing and a tiny-timing generator against a pixel-index raster model.
module tb_dvi_timing_gen;
  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;
  int   pd, ps;
  bit   rst_st;
  dvi_timing_gen_if #(.CW(11)) ifd ();
  dvi_timing_gen_if #(.CW(11)) ifs ();
  dvi_timing_gen dut_d (.clk(clk), .rstn(rstn), .bus(ifd.master));
  dvi_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) dut_s (.clk(clk), .rstn(rstn), .bus(ifs.master));
  always #5 clk = ~clk;
  function automatic logic [28:0] ref_out(int p, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, bit hp, bit vp);
    int  ht  = ha + hf + hs + hb;
    int  h   = p % ht;
    int  v   = p / ht;
    bit  de  = (h < ha) && (v < va);
    bit  hsy = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    bit  vsy = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    return {11'(h), 11'(v), de, hsy, vsy, vsy, hsy, h == 0, p == 0};
  endfunction
  function automatic logic [28:0] ref_rst(int ht, int vt, bit hp, bit vp);
    return {11'(ht - 1), 11'(vt - 1), 1'b0, ~hp, ~vp, ~vp, ~hp, 2'b00};
  endfunction
  function automatic logic [28:0] obs_d();
    return {ifd.x, ifd.y, ifd.dena, ifd.hsync, ifd.vsync, ifd.ctrl, ifd.line_start, ifd.frame_start};
  endfunction
  function automatic logic [28:0] obs_s();
    return {ifs.x, ifs.y, ifs.dena, ifs.hsync, ifs.vsync, ifs.ctrl, ifs.line_start, ifs.frame_start};
  endfunction
  task automatic compare(input string tag, input logic [28:0] o, input logic [28:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all(input string tag);
    compare({tag, "_dflt"}, obs_d(), rst_st ? ref_rst(800, 525, 1'b0, 1'b0)
                                            : ref_out(pd, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0));
    compare({tag, "_small"}, obs_s(), rst_st ? ref_rst(8, 6, 1'b1, 1'b1)
                                             : ref_out(ps, 4, 1, 2, 1, 3, 1, 1, 1'b1, 1'b1));
  endtask
  task automatic step(input bit c, input string tag);
    ifd.ce = c;
    ifs.ce = c;
    @(posedge clk);
    if (c) begin
      if (rst_st) begin
        rst_st = 1'b0;
        pd = 0;
        ps = 0;
      end else begin
        pd = (pd + 1) % (800 * 525);
        ps = (ps + 1) % 48;
      end
    end
    #1;
    check_all(tag);
  endtask
  initial begin
    int n_de, n_hs, n_ls, n_fs, n_vs, guard;
    rst_st = 1'b1;
    pd = 0;
    ps = 0;
    rstn = 1'b0;
    ifd.ce = 1'b0;
    ifs.ce = 1'b0;
    #22;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, "hold_after_rel");
    step(1'b1, "first_ce");
    compare("first_xy", {ifd.x, ifd.y, 7'd0}, 29'd0);
    compare("first_strobes", {26'd0, ifd.dena, ifd.line_start, ifd.frame_start}, 29'd7);
    step(1'b1, "second_ce");
    compare("second_x_fs", {ifd.x, 17'd0, ifd.frame_start}, {11'd1, 18'd0});
    n_de = 0; n_hs = 0; n_ls = 0;
    for (int i = 0; i < 800; i++) begin
      step(1'b1, "line");
      n_de += int'(ifd.dena);
      n_hs += int'(!ifd.hsync);
      n_ls += int'(ifd.line_start);
    end
    compare("line_dena_cnt", 29'(n_de), 29'd640);
    compare("line_hsync_cnt", 29'(n_hs), 29'd96);
    compare("line_ls_cnt", 29'(n_ls), 29'd1);
    for (int i = 0; i < 1600; i++) step(1'(i % 2), "alt_ce");
    for (int i = 0; i < 1500; i++) step(($urandom % 4) != 0, "rand_ce");
    n_fs = 0; n_vs = 0; n_de = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b1, "small_frames");
      n_fs += int'(ifs.frame_start);
      n_vs += int'(ifs.vsync);
      n_de += int'(ifs.dena);
    end
    compare("small_fs_cnt", 29'(n_fs), 29'd2);
    compare("small_vs_cnt", 29'(n_vs), 29'd16);
    compare("small_de_cnt", 29'(n_de), 29'd24);
    guard = 0;
    while (ifd.x != 11'd300 && guard < 2000) begin
      step(1'b1, "seek");
      guard++;
    end
    compare("seek_x300", {18'd0, ifd.x}, 29'd300);
    #1 rstn = 1'b0;
    rst_st = 1'b1;
    #1;
    check_all("async_rst");
    compare("async_rst_sync", {27'd0, ifd.hsync, ifd.vsync}, 29'd3);
    #1 rstn = 1'b1;
    step(1'b1, "restart");
    compare("restart_fs", {ifd.x, ifd.y, 6'd0, ifd.frame_start}, 29'd1);
    for (int i = 0; i < 200; i++) step(($urandom % 3) != 0, "rand_tail");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
